// File: rtl/task_sequencer_if.sv
// task_sequencer_if
// Bundles the shared-memory (BRAM) port, the task-core sideband and the two
// streams that connect the sequencer to its task core.
//   master : sequencer side (drives BRAM strobes, input stream, out_tready)
//   slave  : memory/core side (drives read data, cfg_n_in, in_tready,
//            output stream)
interface task_sequencer_if;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [16:0] bram_addr;
  logic [31:0] bram_wrdata;
  logic [31:0] bram_rddata;
  logic [7:0]  task_id;
  logic [9:0]  cfg_n_in;
  logic [31:0] in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic        in_tlast;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tlast;

  modport master (
    output bram_en, bram_we, bram_addr, bram_wrdata, task_id,
    output in_tdata, in_tvalid, in_tlast, out_tready,
    input  bram_rddata, cfg_n_in, in_tready, out_tdata, out_tvalid, out_tlast
  );

  modport slave (
    input  bram_en, bram_we, bram_addr, bram_wrdata, task_id,
    input  in_tdata, in_tvalid, in_tlast, out_tready,
    output bram_rddata, cfg_n_in, in_tready, out_tdata, out_tvalid, out_tlast
  );
endinterface

// File: rtl/task_sequencer.sv
// task_sequencer
// Mailbox-driven job sequencer. After announcing itself in shared memory it
// polls TV_IN_READY, fetches the task number, validates it, streams the input
// region to the task core, stores the core's results in the output region and
// raises TV_OUT_READY. All outputs are registered.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   bus           : task_sequencer_if.master (BRAM port, task_id, cfg_n_in,
//                   input stream to core, result stream from core)
//   busy          : high while a job is in progress (GET_TASK..DONE)
//   err           : sticky error (bad task or output overflow)
module task_sequencer #(
  parameter logic [31:0] ENABLED_MASK = 32'h0000_7FFF,
  parameter int unsigned MAX_WORDS    = 512
) (
  input  logic             aclk,
  input  logic             aresetn,
  task_sequencer_if.master bus,
  output logic             busy,
  output logic             err
);

  localparam logic [16:0] ADDR_IN_BASE  = 17'h00000;
  localparam logic [16:0] ADDR_OUT_BASE = 17'h00800;
  localparam logic [16:0] ADDR_PL_RDY   = 17'h10000;
  localparam logic [16:0] ADDR_EN_TASKS = 17'h10004;
  localparam logic [16:0] ADDR_CUR_TASK = 17'h10008;
  localparam logic [16:0] ADDR_TV_IN    = 17'h1000C;
  localparam logic [16:0] ADDR_TV_OUT   = 17'h10010;
  localparam logic [10:0] MAX_W         = 11'(MAX_WORDS);

  typedef enum logic [3:0] {
    S_INIT_RDY, S_INIT_EN, S_POLL, S_GET_TASK, S_CHECK,
    S_ARM, S_LOAD, S_DRAIN, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic        bram_en_q, bram_en_d;
  logic [3:0]  bram_we_q, bram_we_d;
  logic [16:0] bram_addr_q, bram_addr_d;
  logic [31:0] bram_wrdata_q, bram_wrdata_d;
  logic        rd_vld_q, rd_vld_d;
  logic [7:0]  task_id_q, task_id_d;
  logic [9:0]  n_q, n_d, i_q, i_d, j_q, j_d;
  logic [31:0] in_tdata_q, in_tdata_d;
  logic        in_tvalid_q, in_tvalid_d;
  logic        in_tlast_q, in_tlast_d;
  logic        out_tready_q, out_tready_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [9:0]  i_next_s;

  // Task 1..32 maps to ENABLED_MASK bit 0..31; word count must be 1..MAX_WORDS.
  function automatic logic task_rejected(input logic [7:0] id, input logic [9:0] n);
    logic [4:0] idx;
    logic       bad;
    idx = id[4:0] - 5'd1;
    if ((id == 8'd0) || (id > 8'd32)) begin
      bad = 1'b1;
    end else if (ENABLED_MASK[idx] == 1'b0) begin
      bad = 1'b1;
    end else if ((n == 10'd0) || ({1'b0, n} > MAX_W)) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  assign i_next_s = i_q + 10'd1;

  // Next-state, next-output and datapath computation for the sequencer FSM.
  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    bram_en_d     = 1'b0;
    bram_we_d     = 4'h0;
    bram_addr_d   = bram_addr_q;
    bram_wrdata_d = bram_wrdata_q;
    // Read data is on the bus exactly one cycle after a read strobe.
    rd_vld_d      = bram_en_q && (bram_we_q == 4'h0);
    task_id_d     = task_id_q;
    n_d           = n_q;
    i_d           = i_q;
    j_d           = j_q;
    in_tdata_d    = in_tdata_q;
    in_tvalid_d   = in_tvalid_q;
    in_tlast_d    = in_tlast_q;
    out_tready_d  = out_tready_q;
    err_d         = err_q;

    case (state_q)
      S_INIT_RDY: begin
        bram_en_d     = 1'b1;
        bram_we_d     = 4'hF;
        bram_wrdata_d = 32'h0000_0000;
        case (step_q)
          2'd0: begin
            bram_addr_d = ADDR_TV_OUT;
            step_d      = 2'd1;
          end
          2'd1: begin
            bram_addr_d = ADDR_TV_IN;
            step_d      = 2'd2;
          end
          default: begin
            bram_addr_d   = ADDR_PL_RDY;
            bram_wrdata_d = 32'h0000_0001;
            step_d        = 2'd0;
            state_d       = S_INIT_EN;
          end
        endcase
      end

      S_INIT_EN: begin
        bram_en_d     = 1'b1;
        bram_we_d     = 4'hF;
        bram_addr_d   = ADDR_EN_TASKS;
        bram_wrdata_d = ENABLED_MASK;
        state_d       = S_POLL;
      end

      // A read is issued whenever the port is idle or the previous poll result
      // has just arrived, which gives one poll every two cycles.
      S_POLL: begin
        if (rd_vld_q && (bus.bram_rddata == 32'h0000_0001)) begin
          state_d = S_GET_TASK;
        end else if (rd_vld_q || !bram_en_q) begin
          bram_en_d   = 1'b1;
          bram_addr_d = ADDR_TV_IN;
        end else begin
          state_d = S_POLL;
        end
      end

      S_GET_TASK: begin
        if (rd_vld_q) begin
          task_id_d = bus.bram_rddata[7:0];
          state_d   = S_CHECK;
        end else if (!bram_en_q) begin
          bram_en_d   = 1'b1;
          bram_addr_d = ADDR_CUR_TASK;
        end else begin
          state_d = S_GET_TASK;
        end
      end

      S_CHECK: begin
        if (task_rejected(task_id_q, bus.cfg_n_in)) begin
          bram_en_d     = 1'b1;
          bram_we_d     = 4'hF;
          bram_addr_d   = ADDR_OUT_BASE;
          bram_wrdata_d = {16'hDEAD, 8'h00, task_id_q};
          err_d         = 1'b1;
          state_d       = S_DONE;
        end else begin
          n_d     = bus.cfg_n_in;
          i_d     = 10'd0;
          j_d     = 10'd0;
          step_d  = 2'd0;
          state_d = S_ARM;
        end
      end

      S_ARM: begin
        bram_en_d     = 1'b1;
        bram_we_d     = 4'hF;
        bram_wrdata_d = 32'h0000_0000;
        if (step_q == 2'd0) begin
          bram_addr_d = ADDR_TV_IN;
          step_d      = 2'd1;
        end else begin
          bram_addr_d = ADDR_TV_OUT;
          step_d      = 2'd0;
          state_d     = S_LOAD;
        end
      end

      // i is the index of the word being fetched or presented; the next
      // fetch is launched in the handshake cycle of the current word.
      S_LOAD: begin
        if (in_tvalid_q && bus.in_tready) begin
          in_tvalid_d = 1'b0;
          in_tlast_d  = 1'b0;
          i_d         = i_next_s;
          if (in_tlast_q) begin
            out_tready_d = 1'b1;
            state_d      = S_DRAIN;
          end else begin
            bram_en_d   = 1'b1;
            bram_addr_d = ADDR_IN_BASE + {5'b0_0000, i_next_s, 2'b00};
          end
        end else if (rd_vld_q) begin
          in_tdata_d  = bus.bram_rddata;
          in_tvalid_d = 1'b1;
          in_tlast_d  = (i_q == (n_q - 10'd1));
        end else if (!in_tvalid_q && !bram_en_q) begin
          // First fetch after ARM, once its last write has left the port.
          bram_en_d   = 1'b1;
          bram_addr_d = ADDR_IN_BASE + {5'b0_0000, i_q, 2'b00};
        end else begin
          state_d = S_LOAD;
        end
      end

      // Beats beyond the output region are consumed but not stored; j
      // saturates so an endless stream can never wrap onto word 0.
      S_DRAIN: begin
        if (bus.out_tvalid && out_tready_q) begin
          if ({1'b0, j_q} >= MAX_W) begin
            err_d = 1'b1;
          end else begin
            bram_en_d     = 1'b1;
            bram_we_d     = 4'hF;
            bram_addr_d   = ADDR_OUT_BASE + {5'b0_0000, j_q, 2'b00};
            bram_wrdata_d = bus.out_tdata;
          end
          j_d = (j_q == 10'h3FF) ? j_q : (j_q + 10'd1);
          if (bus.out_tlast) begin
            out_tready_d = 1'b0;
            state_d      = S_DONE;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_DONE: begin
        bram_en_d     = 1'b1;
        bram_we_d     = 4'hF;
        bram_addr_d   = ADDR_TV_OUT;
        bram_wrdata_d = 32'h0000_0001;
        state_d       = S_POLL;
      end

      default: begin
        state_d = S_INIT_RDY;
        step_d  = 2'd0;
      end
    endcase

    busy_d = (state_d inside {S_GET_TASK, S_CHECK, S_ARM, S_LOAD, S_DRAIN, S_DONE});
  end

  // State and registered-output flops; reset abandons any job in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_INIT_RDY;
      step_q        <= 2'd0;
      bram_en_q     <= 1'b0;
      bram_we_q     <= 4'h0;
      bram_addr_q   <= 17'h0_0000;
      bram_wrdata_q <= 32'h0000_0000;
      rd_vld_q      <= 1'b0;
      task_id_q     <= 8'h00;
      n_q           <= 10'd0;
      i_q           <= 10'd0;
      j_q           <= 10'd0;
      in_tdata_q    <= 32'h0000_0000;
      in_tvalid_q   <= 1'b0;
      in_tlast_q    <= 1'b0;
      out_tready_q  <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      bram_en_q     <= bram_en_d;
      bram_we_q     <= bram_we_d;
      bram_addr_q   <= bram_addr_d;
      bram_wrdata_q <= bram_wrdata_d;
      rd_vld_q      <= rd_vld_d;
      task_id_q     <= task_id_d;
      n_q           <= n_d;
      i_q           <= i_d;
      j_q           <= j_d;
      in_tdata_q    <= in_tdata_d;
      in_tvalid_q   <= in_tvalid_d;
      in_tlast_q    <= in_tlast_d;
      out_tready_q  <= out_tready_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign bus.bram_en     = bram_en_q;
  assign bus.bram_we     = bram_we_q;
  assign bus.bram_addr   = bram_addr_q;
  assign bus.bram_wrdata = bram_wrdata_q;
  assign bus.task_id     = task_id_q;
  assign bus.in_tdata    = in_tdata_q;
  assign bus.in_tvalid   = in_tvalid_q;
  assign bus.in_tlast    = in_tlast_q;
  assign bus.out_tready  = out_tready_q;
  assign busy            = busy_q;
  assign err             = err_q;

endmodule
